// File: rtl/alarm_sched.sv
// alarm_sched: four-channel alarm scheduler sharing one 16-bit decrement/compare path.
// Define ALARM_SCHED_SNAP_EN to build the CLO->CHI snapshot registers for tear-free reads.
module alarm_sched #(
  parameter int NCH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] dbr,
  input  logic [7:0] dbw,
  input  logic [4:0] addr,
  input  logic       we,
  output logic       irq
);

  logic [15:0]    reload_q [NCH];
  logic [15:0]    reload_d [NCH];
  logic [15:0]    count_q  [NCH];
  logic [15:0]    count_d  [NCH];
  logic [NCH-1:0] en_q, en_d;
  logic [NCH-1:0] per_q, per_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [1:0]     s_q;
  logic [7:0]     dbr_q, dbr_d;
  logic           irq_q, irq_d;
  logic [1:0]     ch_s;
  logic [2:0]     rsel_s;
  logic           svc_hit_s;
`ifdef ALARM_SCHED_SNAP_EN
  logic [7:0]     snap_q [NCH];
  logic [7:0]     snap_d [NCH];
`endif

  assign ch_s   = addr[4:3];
  assign rsel_s = addr[2:0];
  assign dbr    = dbr_q;
  assign irq    = irq_q;

  // Slot service, then bus write (a write to the serviced channel suppresses its slot), then read mux.
  always_comb begin
    reload_d = reload_q;
    count_d  = count_q;
    en_d     = en_q;
    per_d    = per_q;
    pend_d   = pend_q;
    mask_d   = mask_q;
    dbr_d    = dbr_q;
`ifdef ALARM_SCHED_SNAP_EN
    snap_d   = snap_q;
`endif
    svc_hit_s = we && (ch_s == s_q) && (rsel_s <= 3'd2);

    if (en_q[s_q] && !svc_hit_s) begin
      if (count_q[s_q] == 16'd0) begin
        pend_d[s_q] = 1'b1;
        if (per_q[s_q]) begin
          count_d[s_q] = reload_q[s_q];
        end else begin
          en_d[s_q] = 1'b0;
        end
      end else begin
        count_d[s_q] = count_q[s_q] - 16'd1;
      end
    end else begin
      count_d[s_q] = count_d[s_q];
    end

    if (we) begin
      case (rsel_s)
        3'd0: reload_d[ch_s][7:0]  = dbw;
        3'd1: reload_d[ch_s][15:8] = dbw;
        3'd2: begin
          if (dbw[7]) begin
            pend_d[ch_s] = 1'b0;
          end else begin
            pend_d[ch_s] = pend_d[ch_s];
          end
          per_d[ch_s] = dbw[1];
          en_d[ch_s]  = dbw[0];
          // Only a 0->1 enable edge reloads; disabling parks the count at zero.
          if (!dbw[0]) begin
            count_d[ch_s] = 16'd0;
          end else if (!en_q[ch_s]) begin
            count_d[ch_s] = reload_q[ch_s];
          end else begin
            count_d[ch_s] = count_q[ch_s];
          end
        end
        3'd5: mask_d = dbw[7:4];
        default: mask_d = mask_d;
      endcase
    end else begin
      case (rsel_s)
        3'd0: dbr_d = reload_q[ch_s][7:0];
        3'd1: dbr_d = reload_q[ch_s][15:8];
        3'd2: dbr_d = {pend_q[ch_s], 5'b00000, per_q[ch_s], en_q[ch_s]};
        3'd3: begin
          dbr_d = count_q[ch_s][7:0];
`ifdef ALARM_SCHED_SNAP_EN
          snap_d[ch_s] = count_q[ch_s][15:8];
`endif
        end
`ifdef ALARM_SCHED_SNAP_EN
        3'd4: dbr_d = snap_q[ch_s];
`else
        3'd4: dbr_d = count_q[ch_s][15:8];
`endif
        3'd5: dbr_d = {mask_q, pend_q};
        default: dbr_d = 8'h00;
      endcase
    end

    irq_d = |(pend_q & mask_q);
  end

  // State registers; reset aborts every channel immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        reload_q[c] <= 16'd0;
        count_q[c]  <= 16'd0;
`ifdef ALARM_SCHED_SNAP_EN
        snap_q[c]   <= 8'd0;
`endif
      end
      en_q   <= '0;
      per_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
      s_q    <= 2'd0;
      dbr_q  <= 8'h00;
      irq_q  <= 1'b0;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
`ifdef ALARM_SCHED_SNAP_EN
      snap_q   <= snap_d;
`endif
      en_q   <= en_d;
      per_q  <= per_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
      s_q    <= s_q + 2'd1;
      dbr_q  <= dbr_d;
      irq_q  <= irq_d;
    end
  end

endmodule

// File: tb/tb_alarm_sched.sv
// Directed bench for alarm_sched: reset, periodic, one-shot, collision, CHI read, masking.
module tb_alarm_sched;

  logic       clk;
  logic       rst_n;
  logic [7:0] dbr;
  logic [7:0] dbw;
  logic [4:0] addr;
  logic       we;
  logic       irq;
  logic [1:0] tslot;
  logic [7:0] rdata;
  logic [7:0] exp_chi;
  int         checks;
  int         failures;

  localparam logic [4:0] GLB   = 5'h05;
  localparam logic [4:0] IDLE  = 5'h07;
  localparam logic [4:0] RLO0  = 5'h00, RHI0 = 5'h01, CTRL0 = 5'h02;
  localparam logic [4:0] RLO1  = 5'h08, RHI1 = 5'h09, CTRL1 = 5'h0A, CLO1 = 5'h0B;
  localparam logic [4:0] RLO2  = 5'h10, RHI2 = 5'h11, CTRL2 = 5'h12, CLO2 = 5'h13, CHI2 = 5'h14;
  localparam logic [4:0] RLO3  = 5'h18, RHI3 = 5'h19, CTRL3 = 5'h1A, CLO3 = 5'h1B, CHI3 = 5'h1C;

  alarm_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dbr   (dbr),
    .dbw   (dbw),
    .addr  (addr),
    .we    (we),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slot the scheduler is in during the current cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tslot <= 2'd0;
    else        tslot <= tslot + 2'd1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    addr = a;
    dbw  = d;
    we   = 1'b1;
    tick(1);
    we   = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    addr = a;
    we   = 1'b0;
    tick(1);
    d    = dbr;
    addr = IDLE;
  endtask

  task automatic wait_slot(input logic [1:0] n);
    for (int i = 0; i < 8 && tslot != n; i++) tick(1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    we       = 1'b0;
    addr     = IDLE;
    dbw      = 8'h00;
`ifdef ALARM_SCHED_SNAP_EN
    exp_chi  = 8'h12;
`else
    exp_chi  = 8'h11;
`endif
    tick(2);
    chk("reset_dbr", dbr, 8'h00);
    chk("reset_irq", {7'b0, irq}, 8'h00);
    rst_n = 1'b1;
    tick(1);

    // Periodic ch0, reload 2: expiry on the 3rd service, then every 12 clocks.
    wr(RLO0, 8'h02);
    wr(RHI0, 8'h00);
    wr(GLB, 8'h10);
    wait_slot(2'd1);
    wr(CTRL0, 8'h03);
    addr = GLB;
    tick(11);
    chk("per_glb_before", dbr, 8'h10);
    chk("per_irq_before", {7'b0, irq}, 8'h00);
    tick(1);
    chk("per_glb_set", dbr, 8'h11);
    chk("per_irq_set", {7'b0, irq}, 8'h01);
    wr(CTRL0, 8'h83);
    chk("w1c_irq_same", {7'b0, irq}, 8'h01);
    tick(1);
    chk("w1c_irq_drop", {7'b0, irq}, 8'h00);
    chk("w1c_ctrl_rd", dbr, 8'h03);
    addr = GLB;
    tick(9);
    chk("per2_glb_before", dbr, 8'h10);
    chk("per2_irq_before", {7'b0, irq}, 8'h00);
    tick(1);
    chk("per2_glb_set", dbr, 8'h11);
    chk("per2_irq_set", {7'b0, irq}, 8'h01);
    wr(CTRL0, 8'h80);

    // One-shot ch2, reload 1.
    wr(RLO2, 8'h01);
    wr(RHI2, 8'h00);
    wait_slot(2'd3);
    wr(CTRL2, 8'h01);
    addr = GLB;
    tick(7);
    chk("os_glb_before", dbr, 8'h10);
    tick(1);
    chk("os_glb_set", dbr, 8'h14);
    chk("os_irq_masked", {7'b0, irq}, 8'h00);
    rd(CTRL2, rdata);
    chk("os_ctrl", rdata, 8'h80);
    tick(6);
    rd(CLO2, rdata);
    chk("os_clo", rdata, 8'h00);
    rd(CHI2, rdata);
    chk("os_chi", rdata, 8'h00);
    wr(CTRL2, 8'h80);
    tick(16);
    rd(GLB, rdata);
    chk("os_no_repeat", rdata, 8'h10);

    // Collision: RLO write in slot 1 swallows that service of ch1.
    wr(RLO1, 8'h05);
    wr(RHI1, 8'h00);
    wait_slot(2'd2);
    wr(CTRL1, 8'h03);
    tick(2);
    chk("col_slot", {6'b0, tslot}, 8'h01);
    wr(RLO1, 8'h07);
    addr = CLO1;
    tick(1);
    chk("col_held", dbr, 8'h05);
    tick(3);
    chk("col_held_late", dbr, 8'h05);
    tick(1);
    chk("col_dec", dbr, 8'h04);
    wr(CTRL1, 8'h00);

    // CLO then CHI on ch3.
    wr(RLO3, 8'h34);
    wr(RHI3, 8'h12);
    wr(CTRL3, 8'h01);
    rd(CLO3, rdata);
    chk("snap_clo", rdata, 8'h34);
    tick(8);
    rd(CHI3, rdata);
    chk("snap_chi", rdata, 8'h12);
    wr(CTRL3, 8'h00);
    wr(RLO3, 8'h01);
    wr(CTRL3, 8'h01);
    rd(CLO3, rdata);
    chk("snap_clo_x", rdata, 8'h01);
    tick(8);
    rd(CHI3, rdata);
    chk("snap_chi_x", rdata, exp_chi);

    // Masking: all channels expire with mask 0, then unmask ch2.
    wr(GLB, 8'h00);
    wr(CTRL0, 8'h80);
    wr(CTRL1, 8'h80);
    wr(CTRL2, 8'h80);
    wr(CTRL3, 8'h80);
    wr(RLO3, 8'h00);
    wr(RHI3, 8'h00);
    wr(RLO1, 8'h00);
    wr(RLO2, 8'h00);
    wr(CTRL0, 8'h01);
    wr(CTRL1, 8'h01);
    wr(CTRL2, 8'h01);
    wr(CTRL3, 8'h01);
    tick(20);
    chk("mask_irq_off", {7'b0, irq}, 8'h00);
    rd(GLB, rdata);
    chk("mask_glb", rdata, 8'h0F);
    wr(GLB, 8'h40);
    chk("mask_irq_edge", {7'b0, irq}, 8'h00);
    tick(1);
    chk("mask_irq_on", {7'b0, irq}, 8'h01);
    wr(5'h0E, 8'hFF);
    rd(5'h0E, rdata);
    chk("unused_reg", rdata, 8'h00);

    // Mid-operation reset.
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dbr", dbr, 8'h00);
    chk("mid_rst_irq", {7'b0, irq}, 8'h00);
    tick(2);
    rst_n = 1'b1;
    rd(GLB, rdata);
    chk("post_rst_glb", rdata, 8'h00);
    rd(CTRL0, rdata);
    chk("post_rst_ctrl0", rdata, 8'h00);
    rd(RLO0, rdata);
    chk("post_rst_rlo0", rdata, 8'h00);
    tick(8);
    chk("post_rst_irq", {7'b0, irq}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
